// File: rtl/loader_pkg.sv
// Shared types and constants for the serial program loader.
// States, header size, word geometry and counter width.
package loader_pkg;

  typedef enum logic [2:0] {
    LEN0,
    LEN1,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int CNT_W          = 16;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Little-endian 4-byte shift/assemble register with byte index.
// word_next is the word as it will look after this byte lands.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_full
);

  logic [31:0] word_q;
  logic [1:0]  idx;

  // Bytes shift in from the top so the first lands in bits 7:0.
  assign word_next = {byte_in, word_q[31:8]};
  assign word_full = accept && (idx == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
      idx    <= '0;
    end else if (accept) begin
      word_q <= word_next;
      idx    <= idx + 2'd1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Serial program loader: length header, then words into imem.
// Holds the core in reset until the whole image is written.
module program_loader
  import loader_pkg::*;
#(
  parameter int MAX_WORDS = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             imem_we,
  output logic [63:0]      imem_addr,
  output logic [31:0]      imem_wdata,
  output logic             cpu_reset,
  output logic             load_done,
  output logic             error,
  output logic [CNT_W-1:0] word_count
);

  localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_WORDS);

  state_t           state;
  logic [CNT_W-1:0] n_words;
  logic [CNT_W-1:0] word_idx;
  logic [CNT_W-1:0] n_full;
  logic [CNT_W-1:0] count_inc;
  logic [31:0]      word_next;
  logic             accept;
  logic             asm_accept;
  logic             word_full;

  assign byte_ready = (state == LEN0) ||
                      (state == LEN1) ||
                      (state == DATA);
  assign cpu_reset  = (state != DONE);
  assign load_done  = (state == DONE);
  assign error      = (state == ERR);

  assign accept     = byte_valid && byte_ready;
  assign asm_accept = accept && (state == DATA);
  assign n_full     = {byte_in, n_words[7:0]};
  assign count_inc  = word_count + 16'd1;

  word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .accept    (asm_accept),
    .byte_in   (byte_in),
    .word_next (word_next),
    .word_full (word_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LEN0;
      n_words    <= '0;
      word_idx   <= '0;
      word_count <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      unique case (state)
        LEN0: begin
          if (accept) begin
            n_words[7:0] <= byte_in;
            state        <= LEN1;
          end
        end
        LEN1: begin
          if (accept) begin
            n_words[15:8] <= byte_in;
            if (n_full == '0)
              state <= DONE;
            else if (n_full > MAX_N)
              state <= ERR;
            else
              state <= DATA;
          end
        end
        DATA: begin
          // Strobe and payload are registered on the 4th byte itself,
          // giving a one-cycle write that needs no byte_in path.
          if (word_full) begin
            state      <= WRITE;
            imem_we    <= 1'b1;
            imem_addr  <= 64'({word_idx, 2'b00});
            imem_wdata <= word_next;
          end
        end
        WRITE: begin
          imem_we    <= 1'b0;
          word_idx   <= word_idx + 16'd1;
          word_count <= count_inc;
          state      <= (count_inc == n_words) ? DONE : DATA;
        end
        DONE: ;
        ERR:  ;
        default: state <= LEN0;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader.
// Hand-computed vectors; writes logged at the falling edge.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        imem_we;
  logic [63:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        load_done;
  logic        error;
  logic [15:0] word_count;

  int total = 0;
  int bad = 0;

  int cyc = 0;
  int acc_n = 0;
  int acc_cyc = 0;
  int fall_cyc = -1;
  logic prev_cr = 1'b1;
  logic [63:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  logic        wr_rdy[$];

  program_loader #(.MAX_WORDS(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!reset && byte_valid && byte_ready) begin
      acc_n   = acc_n + 1;
      acc_cyc = cyc;
    end
    if (imem_we) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
      wr_cyc.push_back(cyc);
      wr_rdy.push_back(byte_ready);
    end
    if (prev_cr && !cpu_reset) fall_cyc = cyc;
    prev_cr = cpu_reset;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    byte_valid = 1'b0;
  endtask

  // Present a byte until accepted, then optionally idle gap cycles.
  task automatic put(input logic [7:0] b, input int gap);
    bit ok = 0;
    byte_in = b;
    byte_valid = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (byte_ready) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (ok) begin
      @(posedge clk); #1;
    end
    chk("put_accept", 64'(ok), 64'd1);
    if (gap > 0) begin
      byte_valid = 1'b0;
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic idle(input int n);
    byte_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  logic [7:0] s1[10] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50,
                         8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
  logic [7:0] s2[4]  = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
  logic [7:0] s3[6]  = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int acc0;
    @(posedge clk); #1;
    do_reset();

    // reset state
    chk("rst_ready", 64'(byte_ready), 64'd1);
    chk("rst_cpu_reset", 64'(cpu_reset), 64'd1);
    chk("rst_done", 64'(load_done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_count", 64'(word_count), 64'd0);
    chk("rst_we", 64'(imem_we), 64'd0);
    chk("rst_addr", imem_addr, 64'd0);
    chk("rst_wdata", 64'(imem_wdata), 64'd0);

    // two-word program, valid held high
    base = wr_addr.size();
    foreach (s1[i]) put(s1[i], 0);
    idle(3);
    chk("p2_nwr", 64'(wr_addr.size() - base), 64'd2);
    if (wr_addr.size() - base == 2) begin
      chk("p2_addr0", wr_addr[base], 64'h0);
      chk("p2_data0", 64'(wr_data[base]), 64'h00500013);
      chk("p2_addr1", wr_addr[base+1], 64'h4);
      chk("p2_data1", 64'(wr_data[base+1]), 64'h00A00093);
      chk("p2_lat", 64'(wr_cyc[base+1]), 64'(acc_cyc + 1));
      chk("p2_cr_fall", 64'(fall_cyc), 64'(wr_cyc[base+1] + 1));
    end
    chk("p2_done", 64'(load_done), 64'd1);
    chk("p2_count", 64'(word_count), 64'd2);
    chk("p2_cpu_reset", 64'(cpu_reset), 64'd0);
    chk("p2_ready", 64'(byte_ready), 64'd0);

    // bytes after DONE are ignored
    acc0 = acc_n;
    base = wr_addr.size();
    byte_in = 8'hAA;
    byte_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    chk("post_acc", 64'(acc_n), 64'(acc0));
    chk("post_nwr", 64'(wr_addr.size() - base), 64'd0);
    chk("post_count", 64'(word_count), 64'd2);

    // zero-length header
    do_reset();
    base = wr_addr.size();
    put(8'h00, 0);
    put(8'h00, 0);
    idle(2);
    chk("z_done", 64'(load_done), 64'd1);
    chk("z_cpu_reset", 64'(cpu_reset), 64'd0);
    chk("z_nwr", 64'(wr_addr.size() - base), 64'd0);
    chk("z_count", 64'(word_count), 64'd0);

    // oversize header: 0x41 = 65 > 64
    do_reset();
    base = wr_addr.size();
    put(8'h41, 0);
    put(8'h00, 0);
    acc0 = acc_n;
    byte_in = 8'h13;
    byte_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    chk("e_error", 64'(error), 64'd1);
    chk("e_cpu_reset", 64'(cpu_reset), 64'd1);
    chk("e_done", 64'(load_done), 64'd0);
    chk("e_ready", 64'(byte_ready), 64'd0);
    chk("e_acc", 64'(acc_n), 64'(acc0));
    chk("e_nwr", 64'(wr_addr.size() - base), 64'd0);

    // gappy valid, one word
    do_reset();
    chk("rst2_error", 64'(error), 64'd0);
    base = wr_addr.size();
    put(8'h01, 2);
    put(8'h00, 2);
    foreach (s2[i]) put(s2[i], 2);
    idle(2);
    chk("g_nwr", 64'(wr_addr.size() - base), 64'd1);
    if (wr_addr.size() - base == 1) begin
      chk("g_addr", wr_addr[base], 64'h0);
      chk("g_data", 64'(wr_data[base]), 64'hDEADBEEF);
      chk("g_lat", 64'(wr_cyc[base]), 64'(acc_cyc + 1));
      chk("g_ready_wr", 64'(wr_rdy[base]), 64'd0);
    end
    chk("g_done", 64'(load_done), 64'd1);
    chk("g_count", 64'(word_count), 64'd1);

    // reset mid-word with a byte on offer, then restream
    do_reset();
    put(8'h03, 0);
    put(8'h00, 0);
    put(8'h13, 0);
    put(8'h00, 0);
    byte_in = 8'h50;
    byte_valid = 1'b1;
    do_reset();
    chk("m_count", 64'(word_count), 64'd0);
    chk("m_cpu_reset", 64'(cpu_reset), 64'd1);
    chk("m_ready", 64'(byte_ready), 64'd1);
    base = wr_addr.size();
    foreach (s3[i]) put(s3[i], 0);
    idle(3);
    chk("m_nwr", 64'(wr_addr.size() - base), 64'd1);
    if (wr_addr.size() - base == 1) begin
      chk("m_addr", wr_addr[base], 64'h0);
      chk("m_data", 64'(wr_data[base]), 64'h44332211);
    end
    chk("m_count2", 64'(word_count), 64'd1);
    chk("m_done", 64'(load_done), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
